// File: rtl/nvram_upload.sv
// nvram_upload: serves work-RAM bytes to the HPS over the ioctl upload path while the CPU is paused.
// Optional NVRAM_CHECKSUM_EN: a read one past the region returns the 8-bit sum of in-region bytes.
module nvram_upload #(
    parameter int          ADDR_W        = 11,
    parameter int          REGION_SIZE   = 1024,
    parameter logic [7:0]  UPLOAD_INDEX  = 8'd4,
    parameter logic [15:0] PAUSE_TIMEOUT = 16'd4096
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              pause_req,
    input  logic              pause_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [7:0]        ram_q,
    output logic              timeout_flag
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] PAUSE_WAIT = 3'd1;
    localparam logic [2:0] READY      = 3'd2;
    localparam logic [2:0] FETCH      = 3'd3;
    localparam logic [2:0] LATCH      = 3'd4;

    logic [2:0]  state;
    logic [15:0] timer;
    logic        active;
    logic        active_d;
    logic        in_region;
    logic        hit;
    logic [7:0]  miss_byte;

    assign active    = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
    // Full 25-bit compare so high addresses never alias into RAM.
    assign in_region = ioctl_addr < 25'(REGION_SIZE);

`ifdef NVRAM_CHECKSUM_EN
    logic [7:0] sum;
    logic       sum_sel;

    assign miss_byte = sum_sel ? sum : 8'hFF;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sum     <= 8'h00;
            sum_sel <= 1'b0;
        end else if (state == IDLE && active && !active_d) begin
            sum     <= 8'h00;
        end else if (state != IDLE && active) begin
            if (state == READY && ioctl_rd)
                sum_sel <= ioctl_addr == 25'(REGION_SIZE);
            if (state == LATCH && hit)
                sum <= sum + ram_q;
        end
    end
`else
    assign miss_byte = 8'hFF;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            timer        <= 16'd0;
            active_d     <= 1'b0;
            hit          <= 1'b0;
            ioctl_din    <= 8'hFF;
            ioctl_wait   <= 1'b0;
            pause_req    <= 1'b0;
            ram_addr     <= '0;
            ram_rd       <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            active_d <= active;
            if (state != IDLE && !active) begin
                state      <= IDLE;
                pause_req  <= 1'b0;
                ioctl_wait <= 1'b0;
                ram_rd     <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (active && !active_d) begin
                        state        <= PAUSE_WAIT;
                        pause_req    <= 1'b1;
                        ioctl_wait   <= 1'b1;
                        timer        <= 16'd0;
                        timeout_flag <= 1'b0;
                    end
                    PAUSE_WAIT: begin
                        if (pause_ack) begin
                            state      <= READY;
                            ioctl_wait <= 1'b0;
                        end else if (timer == PAUSE_TIMEOUT - 16'd1) begin
                            state        <= READY;
                            ioctl_wait   <= 1'b0;
                            timeout_flag <= 1'b1;
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end
                    READY: if (ioctl_rd) begin
                        state      <= FETCH;
                        ioctl_wait <= 1'b1;
                        hit        <= in_region;
                        ram_rd     <= in_region;
                        if (in_region)
                            ram_addr <= ioctl_addr[ADDR_W-1:0];
                    end
                    FETCH: begin
                        state  <= LATCH;
                        ram_rd <= 1'b0;
                    end
                    LATCH: begin
                        state      <= READY;
                        ioctl_wait <= 1'b0;
                        ioctl_din  <= hit ? ram_q : miss_byte;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nvram_upload.sv
// tb_nvram_upload: scoreboard bench for nvram_upload with a behavioural synchronous RAM.
module tb_nvram_upload;

`ifdef NVRAM_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_upload = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_rd = 1'b0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        pause_req;
    logic        pause_ack = 1'b0;
    logic [10:0] ram_addr;
    logic        ram_rd;
    logic [7:0]  ram_q = 8'h00;
    logic        timeout_flag;

    logic [7:0] mem [0:2047];
    logic [7:0] sb [$];
    logic [7:0] sum_m;
    int n_tests = 0;
    int n_fail = 0;

    nvram_upload #(.PAUSE_TIMEOUT(16'd16)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
        .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
        .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .pause_req(pause_req),
        .pause_ack(pause_ack), .ram_addr(ram_addr), .ram_rd(ram_rd),
        .ram_q(ram_q), .timeout_flag(timeout_flag)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) if (ram_rd) ram_q <= mem[ram_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_din"}, 32'(ioctl_din), 32'hFF);
        check({tag, "_wait"}, 32'(ioctl_wait), 0);
        check({tag, "_pause"}, 32'(pause_req), 0);
        check({tag, "_addr"}, 32'(ram_addr), 0);
        check({tag, "_rd"}, 32'(ram_rd), 0);
        check({tag, "_tmo"}, 32'(timeout_flag), 0);
    endtask

    task automatic start_session(input int ack_delay, input bit use_ack, input int exp_hi);
        int cnt = 0;
        bit done = 1'b0;
        ioctl_index = 8'd4;
        ioctl_upload = 1'b1;
        sum_m = 8'h00;
        for (int i = 1; i <= 100 && !done; i++) begin
            @(negedge clk_sys);
            if (i == 1) check("pause_req_on", 32'(pause_req), 1);
            if (ioctl_wait) cnt++; else done = 1'b1;
            if (use_ack && i == ack_delay + 1) pause_ack = 1'b1;
        end
        check("wait_hi_cycles", 32'(cnt), 32'(exp_hi));
        check("pause_req_ready", 32'(pause_req), 1);
        check("timeout_flag", 32'(timeout_flag), use_ack ? 0 : 1);
    endtask

    task automatic end_session();
        ioctl_upload = 1'b0;
        pause_ack = 1'b0;
        @(negedge clk_sys);
        check("end_pause_req", 32'(pause_req), 0);
        check("end_wait", 32'(ioctl_wait), 0);
        @(negedge clk_sys);
    endtask

    task automatic do_read(input logic [24:0] a, input bit spurious);
        logic [7:0] e;
        bit inr;
        int wc = 0;
        int rc = 0;
        inr = a < 25'd1024;
        e = inr ? mem[a[10:0]] : (CHK && a == 25'd1024) ? sum_m : 8'hFF;
        if (inr) sum_m = sum_m + mem[a[10:0]];
        sb.push_back(e);
        ioctl_addr = a;
        ioctl_rd = 1'b1;
        @(negedge clk_sys);
        if (inr) check("ram_addr", 32'(ram_addr), 32'(a[10:0]));
        if (spurious) ioctl_addr = a + 25'd1; else ioctl_rd = 1'b0;
        while (ioctl_wait && wc < 10) begin
            wc++;
            if (ram_rd) rc++;
            @(negedge clk_sys);
            ioctl_rd = 1'b0;
        end
        check("wait_cycles", 32'(wc), 2);
        check("ram_rd_cycles", 32'(rc), inr ? 1 : 0);
        check("sb_size", 32'(sb.size()), 1);
        if (sb.size() != 0) check("din", 32'(ioctl_din), 32'(sb.pop_front()));
    endtask

    initial begin
        logic [7:0] d0;
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
        mem[5] = 8'hA7;
        mem[6] = 8'h5C;
        mem[7] = 8'h3E;
        #12;
        check_reset_vals("reset");
        @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);

        ioctl_index = 8'd3;
        ioctl_upload = 1'b1;
        ioctl_addr = 25'd5;
        ioctl_rd = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_sys);
            check("wrong_idx_pause", 32'(pause_req), 0);
            check("wrong_idx_rd", 32'(ram_rd), 0);
        end
        ioctl_rd = 1'b0;
        ioctl_upload = 1'b0;
        @(negedge clk_sys);

        start_session(10, 1'b1, 11);
        do_read(25'd5, 1'b0);
        do_read(25'd5, 1'b1);
        do_read(25'd1025, 1'b0);
        do_read(25'h1000005, 1'b0);
        do_read(25'd0, 1'b0);
        do_read(25'd1023, 1'b0);
        do_read(25'd1024, 1'b0);
        pause_ack = 1'b0;
        @(negedge clk_sys);
        check("ack_drop_pause", 32'(pause_req), 1);
        do_read(25'd6, 1'b0);

        d0 = ioctl_din;
        ioctl_addr = 25'd7;
        ioctl_rd = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        ioctl_upload = 1'b0;
        @(negedge clk_sys);
        check("abort_pause", 32'(pause_req), 0);
        check("abort_wait", 32'(ioctl_wait), 0);
        check("abort_rd", 32'(ram_rd), 0);
        repeat (3) @(negedge clk_sys);
        check("abort_din_held", 32'(ioctl_din), 32'(d0));

        start_session(0, 1'b0, 16);
        do_read(25'd6, 1'b0);
        end_session();

`ifdef NVRAM_CHECKSUM_EN
        for (int i = 0; i < 1024; i++) mem[i] = 8'h01;
        start_session(2, 1'b1, 3);
        for (int a = 0; a <= 1024; a++) do_read(25'(a), 1'b0);
        check("checksum_all_ones", 32'(ioctl_din), 32'h00);
        end_session();
        mem[0] = 8'h03;
        start_session(2, 1'b1, 3);
        for (int a = 0; a <= 1024; a++) do_read(25'(a), 1'b0);
        check("checksum_first_3", 32'(ioctl_din), 32'h02);
        end_session();
`endif

        start_session(1, 1'b1, 2);
        do_read(25'd5, 1'b0);
        ioctl_addr = 25'd6;
        ioctl_rd = 1'b1;
        @(posedge clk_sys);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        ioctl_rd = 1'b0;
        ioctl_upload = 1'b0;
        pause_ack = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
        check("post_reset_pause", 32'(pause_req), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
